// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler
//   Feeds a frame of image rows, one at a time, to a convolution engine and
//   returns each engine result row with its frame row index. A one-entry
//   input buffer lets the next row arrive while the engine is still working.
//   A watchdog flags an engine that never completes.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   frame_start/abort     one-cycle frame control pulses
//   cfg_rows              rows in the frame, sampled on an accepted frame_start
//   in_valid/in_ready     input row handshake, in_row byte k = pixel k
//   eng_start, eng_row    engine start pulse and row, held until next start
//   eng_done, eng_result  engine completion pulse and 30 x 18-bit results
//   out_valid/out_ready   result row handshake with out_row/out_row_idx/out_last
//   busy, frame_done      frame activity and completion pulse
//   timeout_err           sticky watchdog error, cleared only by abort/reset
module conv_row_scheduler #(
  parameter int NUM_ROWS_MAX = 32,
  parameter int TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         frame_abort,
  input  logic [5:0]   cfg_rows,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_row,
  output logic         eng_start,
  output logic [255:0] eng_row,
  input  logic         eng_done,
  input  logic [539:0] eng_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [539:0] out_row,
  output logic [5:0]   out_row_idx,
  output logic         out_last,
  output logic         busy,
  output logic         frame_done,
  output logic         timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_RUN, S_CAPTURE, S_DRAIN, S_ERROR
  } state_t;

  state_t state_reg, state_next;

  logic [5:0]      rows_reg;
  logic [5:0]      acc_cnt_reg;     // rows accepted on the input side
  logic [5:0]      issue_cnt_reg;   // rows handed to the engine
  logic [5:0]      issue_idx_reg;   // frame index of the row in the engine
  logic            buf_full_reg;
  logic [255:0]    buf_data_reg;
  logic [WD_W-1:0] wd_reg;
  logic            eng_start_reg;
  logic [255:0]    eng_row_reg;
  logic            out_valid_reg;
  logic [539:0]    out_row_reg;
  logic [5:0]      out_row_idx_reg;
  logic            out_last_reg;
  logic            frame_done_reg;
  logic            timeout_err_reg;

  logic cfg_ok, start_ok, in_hs, out_hs, issue_go, capture_go, is_last, wd_expire;

  assign cfg_ok     = (cfg_rows != 6'd0) && (int'(cfg_rows) <= NUM_ROWS_MAX);
  assign start_ok   = (state_reg == S_IDLE) && frame_start && cfg_ok && !frame_abort;
  assign busy       = (state_reg != S_IDLE);
  assign in_ready   = busy && (state_reg != S_ERROR) && !buf_full_reg &&
                      (acc_cnt_reg < rows_reg);
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid_reg && out_ready;
  assign issue_go   = (state_reg == S_FETCH) && buf_full_reg;
  // A new result may be captured when the output register is empty or is
  // being emptied in this very cycle.
  assign capture_go = (state_reg == S_CAPTURE) && (!out_valid_reg || out_ready);
  assign is_last    = (issue_idx_reg == rows_reg - 6'd1);
  assign wd_expire  = (wd_reg == WD_W'(TIMEOUT - 1));

  assign eng_start   = eng_start_reg;
  assign eng_row     = eng_row_reg;
  assign out_valid   = out_valid_reg;
  assign out_row     = out_row_reg;
  assign out_row_idx = out_row_idx_reg;
  assign out_last    = out_last_reg;
  assign frame_done  = frame_done_reg;
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:    if (start_ok) state_next = S_FETCH;
      S_FETCH:   if (buf_full_reg) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_RUN;
      S_RUN: begin
        if (eng_done)       state_next = S_CAPTURE;
        else if (wd_expire) state_next = S_ERROR;
      end
      S_CAPTURE: if (capture_go) state_next = is_last ? S_DRAIN : S_FETCH;
      S_DRAIN:   if (out_hs) state_next = S_IDLE;
      S_ERROR:   state_next = S_ERROR;
      default:   state_next = S_IDLE;
    endcase
    if (frame_abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_reg        <= '0;
      acc_cnt_reg     <= '0;
      issue_cnt_reg   <= '0;
      issue_idx_reg   <= '0;
      buf_full_reg    <= 1'b0;
      buf_data_reg    <= '0;
      wd_reg          <= '0;
      eng_start_reg   <= 1'b0;
      eng_row_reg     <= '0;
      out_valid_reg   <= 1'b0;
      out_row_reg     <= '0;
      out_row_idx_reg <= '0;
      out_last_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else if (frame_abort) begin
      acc_cnt_reg     <= '0;
      issue_cnt_reg   <= '0;
      issue_idx_reg   <= '0;
      buf_full_reg    <= 1'b0;
      buf_data_reg    <= '0;
      wd_reg          <= '0;
      eng_start_reg   <= 1'b0;
      out_valid_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      eng_start_reg  <= 1'b0;
      frame_done_reg <= 1'b0;

      if (start_ok) begin
        rows_reg      <= cfg_rows;
        acc_cnt_reg   <= '0;
        issue_cnt_reg <= '0;
        buf_full_reg  <= 1'b0;
      end

      if (in_hs) begin
        buf_data_reg <= in_row;
        buf_full_reg <= 1'b1;
        acc_cnt_reg  <= acc_cnt_reg + 6'd1;
      end

      // Start pulse and row are registered together on the way into ISSUE,
      // so eng_row is already valid in the cycle eng_start is high. The
      // buffer empties here, letting the next row prefetch from ISSUE on.
      if (issue_go) begin
        eng_start_reg <= 1'b1;
        eng_row_reg   <= buf_data_reg;
        buf_full_reg  <= 1'b0;
      end

      if (state_reg == S_ISSUE) begin
        issue_idx_reg <= issue_cnt_reg;
        issue_cnt_reg <= issue_cnt_reg + 6'd1;
        wd_reg        <= '0;
      end

      if (state_reg == S_RUN) begin
        wd_reg <= wd_reg + 1'b1;
        if (!eng_done && wd_expire) timeout_err_reg <= 1'b1;
      end

      if (capture_go) begin
        out_row_reg     <= eng_result;
        out_row_idx_reg <= issue_idx_reg;
        out_last_reg    <= is_last;
        out_valid_reg   <= 1'b1;
      end else if (out_hs) begin
        out_valid_reg <= 1'b0;
      end

      if ((state_reg == S_DRAIN) && out_hs) frame_done_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler
//   Randomised frames against a scoreboard: every accepted input row pushes
//   its expected result (engine function of the row, frame index, last flag)
//   and a monitor pops on every output handshake. An engine model answers
//   eng_start after a programmable latency. Directed sections cover latency,
//   output back-pressure, the watchdog, ignored starts, stray done and reset.
module tb_conv_row_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         frame_start = 1'b0;
  logic         frame_abort = 1'b0;
  logic [5:0]   cfg_rows = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_row = '0;
  logic         eng_start;
  logic [255:0] eng_row;
  logic         eng_done;
  logic [539:0] eng_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [539:0] out_row;
  logic [5:0]   out_row_idx;
  logic         out_last;
  logic         busy;
  logic         frame_done;
  logic         timeout_err;

  conv_row_scheduler #(.NUM_ROWS_MAX(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
    .cfg_rows(cfg_rows), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .eng_start(eng_start), .eng_row(eng_row), .eng_done(eng_done),
    .eng_result(eng_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [539:0] res;
    logic [5:0]   idx;
    logic         last;
  } exp_t;
  exp_t sb[$];

  // Engine transfer function: any fixed function of the row will do, since the
  // scheduler must pass results through untouched.
  function automatic logic [539:0] eng_fn(input logic [255:0] r);
    logic [539:0] v;
    int a, b, c, val;
    v = '0;
    for (int k = 0; k < 30; k++) begin
      a = int'(r[k*8 +: 8]);
      b = int'(r[(k+1)*8 +: 8]);
      c = int'(r[(k+2)*8 +: 8]);
      val = a * c - b * 37 - k * 1000 + a;
      v[k*18 +: 18] = val[17:0];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [539:0] act, input logic [539:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- engine model ----------------
  logic         eng_done_m = 1'b0;
  logic         eng_stray = 1'b0;
  logic         eng_hang = 1'b0;
  logic         eng_kill = 1'b0;
  int           eng_lat_fixed = 0;
  int           eng_cnt = 0;
  logic [255:0] eng_hold = '0;
  assign eng_done = eng_done_m | eng_stray;

  initial begin
    forever begin
      @(negedge clk);
      eng_done_m = 1'b0;
      if (eng_kill) eng_cnt = 0;
      else if (eng_start) begin
        eng_hold = eng_row;
        eng_cnt = eng_hang ? 0 : ((eng_lat_fixed != 0) ? eng_lat_fixed : int'($urandom_range(1, 80)));
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done_m = 1'b1;
          eng_result = eng_fn(eng_hold);
        end
      end
    end
  end

  // ---------------- output consumer ----------------
  int ord_mode = 0; // 0: always ready, 1: random, 2: stalled
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ord_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  int           start_cnt = 0;
  int           last_start_cyc = 0;
  int           pop_cnt = 0;
  int           fd_cnt = 0;
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic         prev_abort = 1'b0;
  logic [539:0] prev_row = '0;
  logic [5:0]   prev_idx = '0;
  logic         prev_last = 1'b0;
  logic [255:0] row_cap = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
        row_cap = '0;
        continue;
      end
      if (eng_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        row_cap = eng_row;
      end else begin
        chk("eng_row_stable", {284'd0, eng_row}, {284'd0, row_cap});
      end
      if (prev_v && !prev_r && !prev_abort) begin
        chk("out_valid_held", {539'd0, out_valid}, 540'd1);
        chk("out_row_held", out_row, prev_row);
        chk("out_idx_held", {534'd0, out_row_idx}, {534'd0, prev_idx});
        chk("out_last_held", {539'd0, out_last}, {539'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got idx %0d, required no output (cycle %0d)", out_row_idx, cyc);
        end else begin
          e = sb.pop_front();
          chk("out_row", out_row, e.res);
          chk("out_row_idx", {534'd0, out_row_idx}, {534'd0, e.idx});
          chk("out_last", {539'd0, out_last}, {539'd0, e.last});
          pop_cnt++;
        end
      end
      if (frame_done) fd_cnt++;
      prev_v = out_valid;
      prev_r = out_ready;
      prev_abort = frame_abort;
      prev_row = out_row;
      prev_idx = out_row_idx;
      prev_last = out_last;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input logic [5:0] rows);
    frame_start = 1'b1;
    cfg_rows = rows;
    sync();
    frame_start = 1'b0;
  endtask

  task automatic send_row(input logic [255:0] r, output int hs_cyc);
    bit got;
    got = 1'b0;
    hs_cyc = -1;
    in_row = r;
    in_valid = 1'b1;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        hs_cyc = cyc;
      end
    end
    sync();
    in_valid = 1'b0;
    chk("in_handshake", {539'd0, got}, 540'd1);
  endtask

  task automatic push_exp(input logic [255:0] r, input int i, input int rows);
    exp_t e;
    e.res = eng_fn(r);
    e.idx = 6'(i);
    e.last = (i == rows - 1);
    sb.push_back(e);
  endtask

  task automatic wait_frame_done(input int fd0);
    for (int n = 0; n < 4000 && fd_cnt == fd0; n++) sync();
    repeat (3) sync();
    chk("frame_done_count", 540'(fd_cnt - fd0), 540'd1);
  endtask

  task automatic run_frame(input int rows, input bit pat, input bit poke);
    int fd0, st0, pf, hs;
    logic [255:0] row;
    logic [7:0] b;
    fd0 = fd_cnt;
    st0 = start_cnt;
    pf = pop_cnt;
    start_frame(6'(rows));
    for (int i = 0; i < rows; i++) begin
      if (pat) begin
        b = 8'(i + 1);
        row = {32{b}};
      end else begin
        row = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(0, 3)) sync();
      end
      send_row(row, hs);
      push_exp(row, i, rows);
      if (i == 0) begin
        @(negedge clk);
        chk("eng_start_t_plus_1", {539'd0, eng_start}, 540'd0);
        @(negedge clk);
        chk("eng_start_t_plus_2", {539'd0, eng_start}, 540'd1);
        chk("eng_row_at_start", {284'd0, eng_row}, {284'd0, row});
        sync();
      end
      if (i == 0 && poke) begin
        start_frame(6'd1);
        for (int n = 0; n < 400 && pop_cnt == pf; n++) sync();
        eng_stray = 1'b1;
        sync();
        eng_stray = 1'b0;
        repeat (3) sync();
        @(negedge clk);
        chk("stray_done_no_capture", {539'd0, out_valid}, 540'd0);
        chk("busy_in_fetch", {539'd0, busy}, 540'd1);
        sync();
      end
    end
    wait_frame_done(fd0);
    chk("scoreboard_empty", 540'(sb.size()), 540'd0);
    chk("start_count", 540'(start_cnt - st0), 540'(rows));
    chk("idle_after_frame", {539'd0, busy}, 540'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fd0, st0, pf, hs, s;
    logic [255:0] row;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {539'd0, busy}, 540'd0);
    chk("rst_in_ready", {539'd0, in_ready}, 540'd0);
    chk("rst_out_valid", {539'd0, out_valid}, 540'd0);
    chk("rst_timeout_err", {539'd0, timeout_err}, 540'd0);
    chk("rst_eng_row", {284'd0, eng_row}, 540'd0);
    sync();
    rst = 1'b1;
    repeat (2) sync();

    // directed 3-row frame, fixed latency, always ready
    ord_mode = 0;
    eng_lat_fixed = 66;
    run_frame(3, 1'b1, 1'b0);

    // ignored starts with bad row counts
    start_frame(6'd0);
    @(negedge clk);
    chk("cfg0_ignored", {539'd0, busy}, 540'd0);
    sync();
    start_frame(6'd33);
    @(negedge clk);
    chk("cfg33_ignored", {539'd0, busy}, 540'd0);
    sync();

    // frame_start while busy and stray eng_done in FETCH
    run_frame(3, 1'b0, 1'b1);

    // randomised frames
    ord_mode = 1;
    eng_lat_fixed = 0;
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(1, 8)), 1'b0, 1'b0);
    run_frame(32, 1'b0, 1'b0);

    // output back-pressure for 200 cycles on a 2-row frame
    ord_mode = 2;
    eng_lat_fixed = 66;
    fd0 = fd_cnt;
    st0 = start_cnt;
    pf = pop_cnt;
    start_frame(6'd2);
    for (int i = 0; i < 2; i++) begin
      row = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_row(row, hs);
      push_exp(row, i, 2);
    end
    repeat (200) sync();
    chk("stall_both_issued", 540'(start_cnt - st0), 540'd2);
    chk("stall_no_pop", 540'(pop_cnt - pf), 540'd0);
    @(negedge clk);
    chk("stall_out_valid", {539'd0, out_valid}, 540'd1);
    chk("stall_out_idx", {534'd0, out_row_idx}, 540'd0);
    sync();
    ord_mode = 0;
    wait_frame_done(fd0);
    chk("stall_no_loss", 540'(pop_cnt - pf), 540'd2);

    // watchdog timeout, then abort (with a simultaneous start) clears it
    eng_hang = 1'b1;
    fd0 = fd_cnt;
    st0 = start_cnt;
    start_frame(6'd1);
    row = {8{$urandom}};
    send_row(row, hs);
    for (int n = 0; n < 20 && start_cnt == st0; n++) sync();
    s = last_start_cyc;
    hs = -1;
    for (int n = 0; n < 400 && hs < 0; n++) begin
      @(negedge clk);
      if (timeout_err) hs = cyc;
    end
    chk("timeout_cycle", 540'(hs), 540'(s + 256));
    chk("timeout_in_ready", {539'd0, in_ready}, 540'd0);
    chk("timeout_busy", {539'd0, busy}, 540'd1);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", {539'd0, timeout_err}, 540'd1);
    chk("error_no_start", 540'(start_cnt - st0), 540'd1);
    sync();
    frame_abort = 1'b1;
    frame_start = 1'b1;
    cfg_rows = 6'd2;
    sync();
    frame_abort = 1'b0;
    frame_start = 1'b0;
    sb.delete();
    eng_hang = 1'b0;
    @(negedge clk);
    chk("abort_busy", {539'd0, busy}, 540'd0);
    chk("abort_timeout_err", {539'd0, timeout_err}, 540'd0);
    repeat (3) sync();
    chk("abort_start_ignored", {539'd0, busy}, 540'd0);
    chk("abort_no_frame_done", 540'(fd_cnt - fd0), 540'd0);

    // asynchronous reset while row 1 of 4 is running
    st0 = start_cnt;
    start_frame(6'd4);
    for (int i = 0; i < 2; i++) begin
      row = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_row(row, hs);
      push_exp(row, i, 4);
    end
    for (int n = 0; n < 300 && start_cnt < st0 + 2; n++) sync();
    repeat (10) sync();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {539'd0, busy}, 540'd0);
    chk("arst_in_ready", {539'd0, in_ready}, 540'd0);
    chk("arst_eng_start", {539'd0, eng_start}, 540'd0);
    chk("arst_out_valid", {539'd0, out_valid}, 540'd0);
    chk("arst_out_last", {539'd0, out_last}, 540'd0);
    chk("arst_frame_done", {539'd0, frame_done}, 540'd0);
    chk("arst_timeout_err", {539'd0, timeout_err}, 540'd0);
    chk("arst_eng_row", {284'd0, eng_row}, 540'd0);
    chk("arst_out_row", out_row, 540'd0);
    chk("arst_out_idx", {534'd0, out_row_idx}, 540'd0);
    sb.delete();
    eng_kill = 1'b1;
    repeat (2) sync();
    rst = 1'b1;
    eng_kill = 1'b0;
    repeat (2) sync();
    run_frame(3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
